// File: rtl/cpu_pkg.sv
// Shared types for the execute/writeback stage.
//   op_t         : 3-bit opcode encoding of the decoded instruction
//   size_t       : write size field (1x = word)
//   exec_state_t : execute-stage sequencer states
//   size_to_mask : write-mask generator, returned at MASK_W bits and cast
//                  down to the datapath width by the user
package cpu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SLL = 3'd5,
        OP_SRL = 3'd6,
        OP_MUL = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } size_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        EXEC = 3'd2,
        MUL  = 3'd3,
        WB   = 3'd4
    } exec_state_t;

    localparam int MASK_W = 64;

    // Both 2'b10 and 2'b11 mean a full-word write.
    function automatic logic [MASK_W-1:0] size_to_mask(input logic [1:0] sz);
        logic [MASK_W-1:0] m;
        if (sz[1])
            m = '1;
        else if (sz[0])
            m = MASK_W'(16'hFFFF);
        else
            m = MASK_W'(8'hFF);
        return m;
    endfunction

endpackage

// File: rtl/exec_stage_if.sv
// Instruction handshake channel into the execute stage.
//   master : decoder side, offers in_valid plus the decoded fields
//   slave  : execute stage, returns in_ready
interface exec_stage_if #(
    parameter int N = 32,
    parameter int M = 2
);
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   in_op;
    logic [M-1:0] in_rd;
    logic [M-1:0] in_rs1;
    logic [M-1:0] in_rs2;
    logic         in_use_imm;
    logic [N-1:0] in_imm;
    logic [1:0]   in_size;

    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, in_use_imm, in_imm, in_size,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_use_imm, in_imm, in_size,
        output in_ready
    );
endinterface

// File: rtl/exec_stage_mul.sv
// Iterative shift-add multiplier, one partial product per cycle, N cycles.
//   clk, rst_n : clock and async active-low reset
//   start      : load a/b and begin (ignored state is overwritten)
//   a, b       : unsigned operands
//   busy       : high while more than one step remains; drops during the
//                final step so the caller can leave in lock-step with it
//   result     : low N bits of a*b, valid once the final step has landed
module mul_iter #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic [N-1:0] result
);
    localparam int CW = $clog2(N + 1);

    logic [N-1:0]  mcand_q;
    logic [N-1:0]  mplier_q;
    logic [N-1:0]  acc_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (start) begin
            mcand_q  <= a;
            mplier_q <= b;
            acc_q    <= '0;
            cnt_q    <= CW'(N);
        end else if (cnt_q != '0) begin
            if (mplier_q[0])
                acc_q <= acc_q + mcand_q;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - CW'(1);
        end
    end

    assign busy   = (cnt_q > CW'(1));
    assign result = acc_q;
endmodule

// File: rtl/exec_stage.sv
// Execute/writeback stage sitting downstream of the register file.
//   clk, rst_n : clock and async active-low reset
//   in_if      : instruction handshake (slave side)
//   r1, r2     : read ids to the register file, held from accept
//   v1, v2     : registered read data, valid in EXEC
//   w1, w, mask: write id, unmasked result, write mask (held between writes)
//   wf, done   : one-cycle write flag (suppressed for rd==0) and retire pulse
//
// state | meaning
// IDLE  | in_ready high, waiting for in_valid
// READ  | register file samples r1/r2
// EXEC  | operands valid; ALU result captured or multiplier started
// MUL   | N shift-add steps
// WB    | result presented to the output registers
module exec_stage
    import cpu_pkg::*;
#(
    parameter int N = 32,
    parameter int M = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    exec_stage_if.slave  in_if,
    output logic [M-1:0] r1,
    output logic [M-1:0] r2,
    input  logic [N-1:0] v1,
    input  logic [N-1:0] v2,
    output logic [M-1:0] w1,
    output logic [N-1:0] w,
    output logic [N-1:0] mask,
    output logic         wf,
    output logic         done
);
    localparam int SHW = $clog2(N);

    exec_state_t  state_q, state_d;
    op_t          op_q;
    logic [M-1:0] rd_q, r1_q, r2_q, w1_q;
    logic         use_imm_q;
    logic [N-1:0] imm_q, res_q, w_q, mask_q;
    logic [1:0]   size_q;
    logic         wf_q, done_q;

    logic         accept, mul_start, mul_busy;
    logic [N-1:0] opa, opb, alu_res, mul_res, wb_data;

    assign accept         = (state_q == IDLE) && in_if.in_valid;
    assign in_if.in_ready = (state_q == IDLE);

    always_comb begin
        opa     = v1;
        opb     = use_imm_q ? imm_q : v2;
        alu_res = '0;
        case (op_q)
            OP_ADD:  alu_res = opa + opb;
            OP_SUB:  alu_res = opa - opb;
            OP_AND:  alu_res = opa & opb;
            OP_OR:   alu_res = opa | opb;
            OP_XOR:  alu_res = opa ^ opb;
            OP_SLL:  alu_res = opa << opb[SHW-1:0];
            OP_SRL:  alu_res = opa >> opb[SHW-1:0];
            default: alu_res = '0;
        endcase
    end

    mul_iter #(.N(N)) u_mul (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (mul_start),
        .a      (opa),
        .b      (opb),
        .busy   (mul_busy),
        .result (mul_res)
    );

    always_comb begin
        state_d   = state_q;
        mul_start = 1'b0;
        case (state_q)
            IDLE: if (in_if.in_valid) state_d = READ;
            READ: state_d = EXEC;
            EXEC: begin
                if (op_q == OP_MUL) begin
                    mul_start = 1'b1;
                    state_d   = MUL;
                end else begin
                    state_d = WB;
                end
            end
            MUL:     if (!mul_busy) state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    assign wb_data = (op_q == OP_MUL) ? mul_res : res_q;

    // Outputs are registered out of WB, so wf/done appear the cycle after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= OP_ADD;
            rd_q      <= '0;
            r1_q      <= '0;
            r2_q      <= '0;
            use_imm_q <= 1'b0;
            imm_q     <= '0;
            size_q    <= '0;
            res_q     <= '0;
            w1_q      <= '0;
            w_q       <= '0;
            mask_q    <= '0;
            wf_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            wf_q   <= 1'b0;
            done_q <= 1'b0;
            if (accept) begin
                op_q      <= op_t'(in_if.in_op);
                rd_q      <= in_if.in_rd;
                r1_q      <= in_if.in_rs1;
                r2_q      <= in_if.in_rs2;
                use_imm_q <= in_if.in_use_imm;
                imm_q     <= in_if.in_imm;
                size_q    <= in_if.in_size;
            end
            if (state_q == EXEC)
                res_q <= alu_res;
            if (state_q == WB) begin
                w1_q   <= rd_q;
                w_q    <= wb_data;
                mask_q <= N'(size_to_mask(size_q));
                wf_q   <= (rd_q != '0);
                done_q <= 1'b1;
            end
        end
    end

    assign r1   = r1_q;
    assign r2   = r2_q;
    assign w1   = w1_q;
    assign w    = w_q;
    assign mask = mask_q;
    assign wf   = wf_q;
    assign done = done_q;
endmodule

// File: tb/tb_exec_stage.sv
module tb_exec_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  r1, r2, w1;
    logic [31:0] v1 = '0, v2 = '0, w, mask;
    logic        wf, done;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    exec_stage_if #(.N(32), .M(2)) ifc ();

    exec_stage #(.N(32), .M(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in_if (ifc),
        .r1    (r1),
        .r2    (r2),
        .v1    (v1),
        .v2    (v2),
        .w1    (w1),
        .w     (w),
        .mask  (mask),
        .wf    (wf),
        .done  (done)
    );

    // Register file environment: registered reads, masked merge writes, r0 fixed at 0.
    logic [31:0] rf [4] = '{default: 32'h0};
    always @(posedge clk) begin
        v1 <= rf[r1];
        v2 <= rf[r2];
        if (wf === 1'b1 && w1 != 2'd0)
            rf[w1] <= (rf[w1] & ~mask) | (w & mask);
    end

    // Reference state: expected architectural register contents.
    logic [31:0] exp_rf [4] = '{default: 32'h0};

    function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] prod;
        int sh;
        sh = int'(b % 32);
        case (op)
            0: return a + b;
            1: return a - b;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return a << sh;
            6: return a >> sh;
            default: begin
                prod = 64'(a) * 64'(b);
                return prod[31:0];
            end
        endcase
    endfunction

    function automatic logic [31:0] ref_mask(input logic [1:0] sz);
        if (sz >= 2) return 32'hFFFF_FFFF;
        if (sz == 1) return 32'h0000_FFFF;
        return 32'h0000_00FF;
    endfunction

    task automatic drive(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                         input logic [1:0] rs2, input logic ui, input logic [31:0] imm,
                         input logic [1:0] sz);
        ifc.in_op      = op;
        ifc.in_rd      = rd;
        ifc.in_rs1     = rs1;
        ifc.in_rs2     = rs2;
        ifc.in_use_imm = ui;
        ifc.in_imm     = imm;
        ifc.in_size    = sz;
    endtask

    // Offer one instruction, wait for its acceptance edge, then count edges to done.
    task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                         input logic [1:0] rs2, input logic ui, input logic [31:0] imm,
                         input logic [1:0] sz, output int lat, output logic owf,
                         output logic [1:0] ow1, output logic [31:0] ow,
                         output logic [31:0] omask, output logic stray);
        int n;
        @(negedge clk);
        drive(op, rd, rs1, rs2, ui, imm, sz);
        ifc.in_valid = 1'b1;
        n = 0;
        while (ifc.in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 ifc.in_valid = 1'b0;
        lat = -1; owf = 1'bx; ow1 = 'x; ow = 'x; omask = 'x; stray = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                lat = k; owf = wf; ow1 = w1; ow = w; omask = mask;
                break;
            end
            if (wf !== 1'b0) stray = 1'b1;
        end
    endtask

    task automatic readback(input logic [1:0] idx, output logic [31:0] val);
        int lat; logic owf, stray; logic [1:0] ow1; logic [31:0] om;
        issue(3'd0, 2'd0, idx, 2'd0, 1'b1, 32'h0, 2'b10, lat, owf, ow1, val, om, stray);
        if (lat != 3) val = 'x;
    endtask

    task automatic load_reg(input logic [1:0] rd, input logic [31:0] val);
        int lat; logic owf, stray; logic [1:0] ow1; logic [31:0] ow, om;
        issue(3'd0, rd, 2'd0, 2'd0, 1'b1, val, 2'b10, lat, owf, ow1, ow, om, stray);
        if (rd != 0) exp_rf[rd] = val;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        ifc.in_valid = 1'b0;
        drive(3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 32'h0, 2'b00);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ifc.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", ifc.in_ready); end
        checks++; if (wf !== 1'b0) begin failures++; $display("FAIL reset_wf got=%b exp=0", wf); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if ({r1, r2, w1} !== 6'd0) begin failures++; $display("FAIL reset_ids got=%h exp=0", {r1, r2, w1}); end
        checks++; if (mask !== 32'h0) begin failures++; $display("FAIL reset_mask got=%h exp=0", mask); end
        checks++; if (w !== 32'h0) begin failures++; $display("FAIL reset_w got=%h exp=0", w); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (ifc.in_ready !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL post_reset_idle got=%b%b exp=10", ifc.in_ready, done); end
    endtask

    task automatic test_imm_timing;
        int lat; logic owf, stray; logic [1:0] ow1; logic [31:0] ow, om;
        issue(3'd0, 2'd1, 2'd0, 2'd0, 1'b1, 32'd5, 2'b10, lat, owf, ow1, ow, om, stray);
        exp_rf[1] = 32'd5;
        checks++; if (lat != 3) begin failures++; $display("FAIL add_latency got=%0d exp=3", lat); end
        checks++; if (owf !== 1'b1 || ow1 !== 2'd1) begin failures++; $display("FAIL add_wf_w1 got=%b/%0d exp=1/1", owf, ow1); end
        checks++; if (ow !== 32'd5) begin failures++; $display("FAIL add_w got=%h exp=5", ow); end
        checks++; if (om !== 32'hFFFF_FFFF) begin failures++; $display("FAIL add_mask got=%h exp=ffffffff", om); end
        checks++; if (stray !== 1'b0) begin failures++; $display("FAIL add_early_wf got=%b exp=0", stray); end
        @(posedge clk);
        #1;
        checks++; if (wf !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL pulse_width got=%b%b exp=00", wf, done); end
        checks++; if (w !== 32'd5 || w1 !== 2'd1) begin failures++; $display("FAIL hold_w got=%h exp=5", w); end
        issue(3'd1, 2'd2, 2'd1, 2'd0, 1'b1, 32'd6, 2'b11, lat, owf, ow1, ow, om, stray);
        exp_rf[2] = 32'hFFFF_FFFF;
        checks++; if (ow !== 32'hFFFF_FFFF || owf !== 1'b1 || lat != 3) begin failures++; $display("FAIL sub_wrap got=%h lat=%0d exp=ffffffff lat=3", ow, lat); end
    endtask

    task automatic test_byte_write;
        int lat; logic owf, stray; logic [1:0] ow1; logic [31:0] ow, om, rb;
        load_reg(2'd1, 32'h1234_5678);
        issue(3'd3, 2'd1, 2'd1, 2'd0, 1'b1, 32'hFF, 2'b00, lat, owf, ow1, ow, om, stray);
        exp_rf[1] = 32'h1234_56FF;
        checks++; if (om !== 32'h0000_00FF) begin failures++; $display("FAIL byte_mask got=%h exp=000000ff", om); end
        checks++; if (ow !== 32'h1234_56FF) begin failures++; $display("FAIL byte_w got=%h exp=123456ff", ow); end
        readback(2'd1, rb);
        checks++; if (rb !== 32'h1234_56FF) begin failures++; $display("FAIL byte_readback got=%h exp=123456ff", rb); end
        // unmasked upper bits of the result must not land in the register
        issue(3'd4, 2'd1, 2'd1, 2'd0, 1'b1, 32'hFFFF_0000, 2'b00, lat, owf, ow1, ow, om, stray);
        checks++; if (ow !== 32'hEDCB_56FF) begin failures++; $display("FAIL xor_w got=%h exp=edcb56ff", ow); end
        readback(2'd1, rb);
        checks++; if (rb !== 32'h1234_56FF) begin failures++; $display("FAIL byte_merge got=%h exp=123456ff", rb); end
        issue(3'd0, 2'd2, 2'd1, 2'd0, 1'b1, 32'h1111_1111, 2'b01, lat, owf, ow1, ow, om, stray);
        exp_rf[2] = 32'hFFFF_6810;
        readback(2'd2, rb);
        checks++; if (om !== 32'h0000_FFFF || rb !== 32'hFFFF_6810) begin failures++; $display("FAIL half_merge got=%h/%h exp=0000ffff/ffff6810", om, rb); end
    endtask

    task automatic test_mul;
        int lat, n; logic bad_ready, stray, extra; logic [31:0] got_w, rb; logic [1:0] got_w1; logic got_wf;
        load_reg(2'd1, 32'd7);
        load_reg(2'd2, 32'd6);
        @(negedge clk);
        drive(3'd7, 2'd3, 2'd1, 2'd2, 1'b0, 32'h0, 2'b10);
        ifc.in_valid = 1'b1;
        n = 0;
        while (ifc.in_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 ifc.in_valid = 1'b0;
        lat = -1; bad_ready = 0; stray = 0; got_w = 'x; got_w1 = 'x; got_wf = 1'bx;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin lat = k; got_w = w; got_w1 = w1; got_wf = wf; break; end
            if (wf !== 1'b0) stray = 1'b1;
            if (ifc.in_ready !== 1'b0) bad_ready = 1'b1;
            if (k >= 10 && k < 14) begin
                drive(3'd0, 2'd1, 2'd0, 2'd0, 1'b1, 32'hDEAD, 2'b10);
                ifc.in_valid = 1'b1;
            end else begin
                ifc.in_valid = 1'b0;
            end
        end
        ifc.in_valid = 1'b0;
        exp_rf[3] = 32'd42;
        checks++; if (lat != 35) begin failures++; $display("FAIL mul_latency got=%0d exp=35", lat); end
        checks++; if (got_w !== 32'd42 || got_w1 !== 2'd3 || got_wf !== 1'b1) begin failures++; $display("FAIL mul_result got=%h/%0d/%b exp=2a/3/1", got_w, got_w1, got_wf); end
        checks++; if (bad_ready !== 1'b0) begin failures++; $display("FAIL mul_in_ready got=1 exp=0"); end
        checks++; if (stray !== 1'b0) begin failures++; $display("FAIL mul_early_wf got=1 exp=0"); end
        extra = 0;
        repeat (8) begin @(posedge clk); #1; if (done !== 1'b0) extra = 1; end
        checks++; if (extra !== 1'b0) begin failures++; $display("FAIL mul_ignored_valid got=1 exp=0"); end
        readback(2'd1, rb);
        checks++; if (rb !== 32'd7) begin failures++; $display("FAIL mul_r1_intact got=%h exp=7", rb); end
    endtask

    task automatic test_rd0;
        int lat; logic owf, stray; logic [1:0] ow1; logic [31:0] ow, om, rb;
        issue(3'd0, 2'd0, 2'd0, 2'd0, 1'b1, 32'd9, 2'b10, lat, owf, ow1, ow, om, stray);
        checks++; if (lat != 3 || ow !== 32'd9) begin failures++; $display("FAIL rd0_done got=%0d/%h exp=3/9", lat, ow); end
        checks++; if (owf !== 1'b0 || stray !== 1'b0) begin failures++; $display("FAIL rd0_wf got=%b exp=0", owf); end
        readback(2'd0, rb);
        checks++; if (rb !== 32'd0) begin failures++; $display("FAIL rd0_readback got=%h exp=0", rb); end
    endtask

    task automatic test_midop_reset;
        int lat, n; logic owf, stray, pulse; logic [1:0] ow1; logic [31:0] ow, om, rb;
        @(negedge clk);
        drive(3'd7, 2'd1, 2'd3, 2'd3, 1'b0, 32'h0, 2'b10);
        ifc.in_valid = 1'b1;
        n = 0;
        while (ifc.in_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 ifc.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++; if (ifc.in_ready !== 1'b1) begin failures++; $display("FAIL midreset_in_ready got=%b exp=1", ifc.in_ready); end
        pulse = 0;
        repeat (45) begin @(posedge clk); #1; if (wf !== 1'b0 || done !== 1'b0) pulse = 1; end
        checks++; if (pulse !== 1'b0) begin failures++; $display("FAIL midreset_pulse got=1 exp=0"); end
        readback(2'd1, rb);
        checks++; if (rb !== exp_rf[1]) begin failures++; $display("FAIL midreset_r1 got=%h exp=%h", rb, exp_rf[1]); end
        issue(3'd0, 2'd2, 2'd3, 2'd0, 1'b1, 32'd1, 2'b10, lat, owf, ow1, ow, om, stray);
        exp_rf[2] = 32'd43;
        checks++; if (lat != 3 || ow !== 32'd43 || owf !== 1'b1) begin failures++; $display("FAIL midreset_next_add got=%0d/%h exp=3/2b", lat, ow); end
    endtask

    task automatic test_back_to_back_random;
        int lat, op, exp_lat; logic owf, stray, ui; logic [1:0] ow1, rd, rs1, rs2, sz;
        logic [31:0] ow, om, imm, a, b, r, m, rb;
        for (int i = 0; i < 40; i++) begin
            op  = int'($urandom_range(0, 7));
            rd  = 2'($urandom_range(0, 3));
            rs1 = 2'($urandom_range(0, 3));
            rs2 = 2'($urandom_range(0, 3));
            ui  = 1'($urandom_range(0, 1));
            imm = $urandom;
            if (op == 5 || op == 6) imm = imm % 40;
            sz  = 2'($urandom_range(0, 3));
            a = exp_rf[rs1];
            b = ui ? imm : exp_rf[rs2];
            r = ref_alu(op, a, b);
            m = ref_mask(sz);
            exp_lat = (op == 7) ? 35 : 3;
            issue(3'(op), rd, rs1, rs2, ui, imm, sz, lat, owf, ow1, ow, om, stray);
            checks++; if (lat != exp_lat) begin failures++; $display("FAIL rnd%0d_latency op=%0d got=%0d exp=%0d", i, op, lat, exp_lat); end
            checks++; if (ow !== r) begin failures++; $display("FAIL rnd%0d_w op=%0d got=%h exp=%h", i, op, ow, r); end
            checks++; if (om !== m || ow1 !== rd) begin failures++; $display("FAIL rnd%0d_mask_w1 got=%h/%0d exp=%h/%0d", i, om, ow1, m, rd); end
            checks++; if (owf !== (rd != 0) || stray !== 1'b0) begin failures++; $display("FAIL rnd%0d_wf got=%b stray=%b exp=%b", i, owf, stray, rd != 0); end
            if (rd != 0) exp_rf[rd] = (exp_rf[rd] & ~m) | (r & m);
        end
        for (int j = 0; j < 4; j++) begin
            readback(2'(j), rb);
            checks++; if (rb !== exp_rf[j]) begin failures++; $display("FAIL final_reg%0d got=%h exp=%h", j, rb, exp_rf[j]); end
        end
    endtask

    initial begin
        test_reset;
        test_imm_timing;
        test_byte_write;
        test_mul;
        test_rd0;
        test_midop_reset;
        test_back_to_back_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
